// File: rtl/cam_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_cfg_pkg                                                                |
// | Shared types, table markers and ms-to-cycle helper for the camera          |
// | SCCB init sequencer.                                                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWR_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_ACK = 4'd4,
    ST_GAP      = 4'd5,
    ST_DELAY    = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } seq_state_t;

  localparam logic [7:0] END_REG = 8'hFF;
  localparam logic [7:0] END_VAL = 8'hFF;
  localparam logic [7:0] DLY_REG = 8'hFE;

  function automatic longint unsigned ms_to_cycles(input longint unsigned ms,
                                                   input longint unsigned clk_hz);
    return (ms * clk_hz) / 64'd1000;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_reg_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_reg_rom                                                                |
// | Synchronous-read register table, {reg,val} per entry, one-cycle latency.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cam_reg_rom #(
  parameter int unsigned TABLE_LEN = 128,
  parameter int unsigned IDX_W     = 7,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output logic [15:0]      data
);

  logic [15:0] r_mem [TABLE_LEN];
  logic [15:0] r_data;

  always_ff @(posedge clk) begin
    r_data <= r_mem[addr];
  end

  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/cam_sccb_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_sccb_init_sequencer                                                    |
// | Walks the camera register table after power-up and issues one SCCB write   |
// | per entry, with delay entries, NACK retries and end-of-table handling.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cam_sccb_init_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1000000,
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned TABLE_LEN  = 128,
  parameter int unsigned POWERUP_MS = 10,
  parameter int unsigned GAP_CYCLES = 100,
  parameter int unsigned MAX_RETRY  = 3,
  parameter string       INIT_FILE  = "cam_init.hex",
  localparam int unsigned IDX_W     = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             wr_req,
  output logic [7:0]       wr_dev,
  output logic [7:0]       wr_reg,
  output logic [7:0]       wr_val,
  input  logic             wr_done,
  input  logic             wr_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cur_idx
);

  // Delay entries count whole milliseconds on a ms prescaler, so the cycle
  // counter only has to span one ms, the power-up wait or the gap.
  localparam int unsigned c_ms_cyc  = max_u(32'd1, 32'(ms_to_cycles(64'd1, 64'(CLK_HZ))));
  localparam int unsigned c_pwr_cyc = max_u(32'd1, 32'(ms_to_cycles(64'(POWERUP_MS), 64'(CLK_HZ))));
  localparam int unsigned c_gap_cyc = max_u(32'd1, GAP_CYCLES);
  localparam int unsigned c_cnt_w   = $clog2(max_u(max_u(c_ms_cyc, c_pwr_cyc), c_gap_cyc) + 1);
  localparam int unsigned c_rty_w   = max_u(32'd1, $clog2(MAX_RETRY + 1));

  localparam logic [c_cnt_w-1:0] c_ms_last   = c_cnt_w'(c_ms_cyc - 1);
  localparam logic [c_cnt_w-1:0] c_pwr_last  = c_cnt_w'(c_pwr_cyc - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(c_gap_cyc - 1);
  localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(TABLE_LEN - 1);
  localparam logic [c_rty_w-1:0] c_max_retry = c_rty_w'(MAX_RETRY);

  seq_state_t          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [c_rty_w-1:0]  r_retry;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [7:0]          r_ms_left;
  logic                r_fetch_ph;
  logic                r_at_end;
  logic                r_wr_req;
  logic [7:0]          r_wr_reg;
  logic [7:0]          r_wr_val;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic [15:0]         w_rom_data;
  logic [7:0]          w_rom_reg;
  logic [7:0]          w_rom_val;
  logic                w_is_end;
  logic                w_is_dly;
  logic                w_dly_fin;

  cam_reg_rom #(
    .TABLE_LEN (TABLE_LEN),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (r_idx),
    .data (w_rom_data)
  );

  assign w_rom_reg = w_rom_data[15:8];
  assign w_rom_val = w_rom_data[7:0];
  assign w_is_end  = (w_rom_reg == END_REG) && (w_rom_val == END_VAL);
  assign w_is_dly  = (w_rom_reg == DLY_REG);
  // A zero-length delay entry still spends exactly one cycle in DELAY.
  assign w_dly_fin = (r_ms_left == 8'd0) || ((r_ms_left == 8'd1) && (r_cnt == c_ms_last));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_retry    <= '0;
      r_cnt      <= '0;
      r_ms_left  <= '0;
      r_fetch_ph <= 1'b0;
      r_at_end   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_wr_reg   <= '0;
      r_wr_val   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state  <= ST_PWR_WAIT;
            r_idx    <= '0;
            r_retry  <= '0;
            r_cnt    <= '0;
            r_at_end <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
          end
        end

        ST_PWR_WAIT: begin
          if (r_cnt == c_pwr_last) begin
            r_cnt      <= '0;
            r_fetch_ph <= 1'b0;
            r_state    <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Phase 0 lets the ROM register the entry at r_idx; phase 1 decodes it.
        ST_FETCH: begin
          if (!r_fetch_ph) begin
            r_fetch_ph <= 1'b1;
          end else begin
            r_fetch_ph <= 1'b0;
            if (r_at_end || w_is_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_is_dly) begin
              r_state   <= ST_DELAY;
              r_cnt     <= '0;
              r_ms_left <= w_rom_val;
            end else begin
              r_state  <= ST_ISSUE;
              r_wr_reg <= w_rom_reg;
              r_wr_val <= w_rom_val;
              r_wr_req <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (wr_done) begin
            r_wr_req <= 1'b0;
            r_cnt    <= '0;
            if (!wr_nack) begin
              r_retry <= '0;
              r_state <= ST_GAP;
              if (r_idx == c_last_idx) r_at_end <= 1'b1;
              else                     r_idx    <= r_idx + 1'b1;
            end else if (r_retry < c_max_retry) begin
              r_retry <= r_retry + 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          if (r_cnt == c_gap_last) begin
            r_cnt      <= '0;
            r_fetch_ph <= 1'b0;
            r_state    <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DELAY: begin
          if (w_dly_fin) begin
            r_cnt      <= '0;
            r_fetch_ph <= 1'b0;
            r_state    <= ST_FETCH;
            if (r_idx == c_last_idx) r_at_end <= 1'b1;
            else                     r_idx    <= r_idx + 1'b1;
          end else if (r_cnt == c_ms_last) begin
            r_cnt     <= '0;
            r_ms_left <= r_ms_left - 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_wr_req <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req  = r_wr_req;
  assign wr_dev  = DEV_ADDR;
  assign wr_reg  = r_wr_reg;
  assign wr_val  = r_wr_val;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign cur_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_cam_sccb_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cam_sccb_init_sequencer                                                 |
// | Bench for the SCCB init sequencer against a timeline model of the table.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cam_sccb_init_sequencer;

  localparam int CLK_HZ     = 100000;
  localparam int TABLE_LEN  = 4;
  localparam int POWERUP_MS = 10;
  localparam int GAP_CYCLES = 100;
  localparam int MAX_RETRY  = 3;
  localparam int IDX_W      = 2;
  localparam int MS_CYC     = CLK_HZ / 1000;
  localparam int PWR_CYC    = POWERUP_MS * MS_CYC;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             wr_done = 1'b0;
  logic             wr_nack = 1'b0;
  logic             wr_req;
  logic [7:0]       wr_dev;
  logic [7:0]       wr_reg;
  logic [7:0]       wr_val;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] cur_idx;

  always #5 clk = ~clk;

  cam_sccb_init_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .DEV_ADDR   (8'h42),
    .TABLE_LEN  (TABLE_LEN),
    .POWERUP_MS (POWERUP_MS),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_RETRY  (MAX_RETRY),
    .INIT_FILE  ("")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .wr_req  (wr_req),
    .wr_dev  (wr_dev),
    .wr_reg  (wr_reg),
    .wr_val  (wr_val),
    .wr_done (wr_done),
    .wr_nack (wr_nack),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .cur_idx (cur_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Table image and slave response script (one entry per write attempt).
  logic [15:0] rom [TABLE_LEN];
  int          q_lat[$];
  bit          q_nack[$];

  // Expected timeline, in clock edges after the edge that samples start.
  int          exp_t[$];
  logic [7:0]  exp_r[$];
  logic [7:0]  exp_v[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_idx;
  int          exp_end;

  function automatic void get_resp(input int a, output int lat, output bit nack);
    if (a < q_lat.size()) begin
      lat  = q_lat[a];
      nack = q_nack[a];
    end else begin
      lat  = 5;
      nack = 1'b0;
    end
  endfunction

  // Walk the table as the specification describes: first decision at power-up
  // plus the two-cycle fetch, writes rise on their decision edge, each finished
  // write adds the gap and a fresh fetch, delay entries add N ms (min 1 cycle).
  function automatic void build_model();
    int  t     = PWR_CYC + 2;
    int  idx   = 0;
    int  retry = 0;
    int  a     = 0;
    bit  fin   = 1'b0;
    int  lat;
    bit  nack;
    logic [15:0] e;
    exp_t.delete();
    exp_r.delete();
    exp_v.delete();
    while (!fin) begin
      if (idx == TABLE_LEN) begin
        exp_done = 1'b1; exp_err = 1'b0; exp_idx = TABLE_LEN - 1; exp_end = t; fin = 1'b1;
      end else begin
        e = rom[idx];
        if (e == 16'hFFFF) begin
          exp_done = 1'b1; exp_err = 1'b0; exp_idx = idx; exp_end = t; fin = 1'b1;
        end else if (e[15:8] == 8'hFE) begin
          int d = int'(e[7:0]) * MS_CYC;
          if (d == 0) d = 1;
          t = t + d + 2;
          idx++;
        end else begin
          get_resp(a, lat, nack);
          a++;
          exp_t.push_back(t);
          exp_r.push_back(e[15:8]);
          exp_v.push_back(e[7:0]);
          if (!nack) begin
            idx++;
            retry = 0;
            t = t + lat + GAP_CYCLES + 2;
          end else if (retry < MAX_RETRY) begin
            retry++;
            t = t + lat + GAP_CYCLES + 2;
          end else begin
            exp_done = 1'b0; exp_err = 1'b1; exp_idx = idx; exp_end = t + lat; fin = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic load_rom();
    for (int i = 0; i < TABLE_LEN; i++) dut.u_rom.r_mem[i] = rom[i];
  endtask

  task automatic run_seq(input string name, input bit noisy);
    int         k        = 0;
    int         a        = 0;
    int         resp_at  = -1;
    int         unstable = 0;
    int         limit;
    int         lat;
    bit         nack;
    bit         cur_nack = 1'b0;
    bit         prev_req = 1'b0;
    logic [7:0] cur_r    = 8'h00;
    logic [7:0] cur_v    = 8'h00;
    int         ot[$];
    logic [7:0] orr[$];
    logic [7:0] ov[$];

    load_rom();
    build_model();
    limit = exp_end + 40;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq({name, ".busy_at_start"}, busy, 1'b1);
    check_eq({name, ".flags_cleared"}, {done, error}, 2'b00);
    check_eq({name, ".idx_at_start"}, cur_idx, 0);

    while (k < limit) begin
      @(posedge clk); #1;
      k++;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      start   = 1'b0;
      if (resp_at == k) check_eq({name, ".req_drop"}, wr_req, 1'b0);
      if (wr_req && !prev_req) begin
        ot.push_back(k);
        orr.push_back(wr_reg);
        ov.push_back(wr_val);
        cur_r = wr_reg;
        cur_v = wr_val;
        get_resp(a, lat, nack);
        a++;
        cur_nack = nack;
        resp_at  = k + lat;
      end else if (wr_req && ((wr_reg != cur_r) || (wr_val != cur_v))) begin
        unstable++;
      end
      if (resp_at == k + 1) begin
        wr_done = 1'b1;
        wr_nack = cur_nack;
        if (noisy) start = 1'b1;
      end
      if (noisy && (k == PWR_CYC / 2)) start = 1'b1;
      prev_req = wr_req;
    end

    check_eq({name, ".n_writes"}, ot.size(), exp_t.size());
    for (int i = 0; i < ot.size() && i < exp_t.size(); i++) begin
      check_eq($sformatf("%s.w%0d.rise", name, i), ot[i], exp_t[i]);
      check_eq($sformatf("%s.w%0d.reg", name, i), orr[i], exp_r[i]);
      check_eq($sformatf("%s.w%0d.val", name, i), ov[i], exp_v[i]);
    end
    check_eq({name, ".fields_stable"}, unstable, 0);
    check_eq({name, ".done"}, done, exp_done);
    check_eq({name, ".error"}, error, exp_err);
    check_eq({name, ".busy"}, busy, 1'b0);
    check_eq({name, ".wr_req"}, wr_req, 1'b0);
    check_eq({name, ".cur_idx"}, cur_idx, exp_idx);
    check_eq({name, ".wr_dev"}, wr_dev, 8'h42);
  endtask

  task automatic reset_test();
    int k   = 0;
    int act = 0;
    rom = '{16'h1280, 16'hFFFF, 16'h0000, 16'h0000};
    q_lat.delete();
    q_nack.delete();
    load_rom();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!wr_req && k < PWR_CYC + 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("rst.req_seen", wr_req, 1'b1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst.req_async_drop", wr_req, 1'b0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.flags", {done, error}, 2'b00);
    check_eq("rst.cur_idx", cur_idx, 0);
    check_eq("rst.fields", {wr_reg, wr_val}, 16'h0000);
    check_eq("rst.wr_dev", wr_dev, 8'h42);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (wr_req || busy || done || error) act++;
    end
    check_eq("rst.no_activity", act, 0);
  endtask

  task automatic make_random();
    for (int i = 0; i < TABLE_LEN; i++) begin
      int sel = int'($urandom_range(0, 99));
      if (sel < 15)      rom[i] = 16'hFFFF;
      else if (sel < 35) rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
      else               rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
    end
    q_lat.delete();
    q_nack.delete();
    for (int i = 0; i < 20; i++) begin
      q_lat.push_back(int'($urandom_range(2, 25)));
      q_nack.push_back($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.wr_req", wr_req, 1'b0);
    check_eq("reset.status", {busy, done, error}, 3'b000);
    check_eq("reset.cur_idx", cur_idx, 0);
    check_eq("reset.fields", {wr_dev, wr_reg, wr_val}, 24'h420000);
    reset_n = 1'b1;

    rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    q_lat = '{20, 20};
    q_nack = '{1'b0, 1'b0};
    run_seq("basic", 1'b0);

    rom = '{16'hFE05, 16'h3A04, 16'hFFFF, 16'h0000};
    q_lat = '{20};
    q_nack = '{1'b0};
    run_seq("delay", 1'b0);

    rom = '{16'h40D0, 16'hFFFF, 16'h0000, 16'h0000};
    q_lat = '{7, 12, 9};
    q_nack = '{1'b1, 1'b1, 1'b0};
    run_seq("nack2", 1'b0);

    rom = '{16'h1280, 16'h40D0, 16'hFFFF, 16'h0000};
    q_lat = '{6, 6, 6, 6, 6};
    q_nack = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    run_seq("nack4", 1'b1);
    q_lat.delete();
    q_nack.delete();
    run_seq("rerun", 1'b0);

    reset_test();

    rom = '{16'h1111, 16'h2222, 16'hFE00, 16'h4444};
    q_lat = '{3, 4, 5};
    q_nack = '{1'b0, 1'b0, 1'b0};
    run_seq("nomarker", 1'b1);

    rom = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    q_lat.delete();
    q_nack.delete();
    run_seq("fourwr", 1'b1);

    for (int r = 0; r < 6; r++) begin
      make_random();
      run_seq($sformatf("rand%0d", r), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
